// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring divide, with architectural HI/LO registers.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUCtrl,
  input  logic [WIDTH-1:0]   read_data_1,
  input  logic [WIDTH-1:0]   read_data_2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALU_result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               Zero,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;
  localparam logic [3:0] OP_MULT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s, div_rem_s, div_quo_s;
  logic             last_s;

  function automatic logic [WIDTH-1:0] single_op(
    input logic [3:0]         ctrl,
    input logic [WIDTH-1:0]   a,
    input logic [WIDTH-1:0]   b,
    input logic [SHAMT_W-1:0] sh,
    input logic [WIDTH-1:0]   h,
    input logic [WIDTH-1:0]   l
  );
    logic [WIDTH-1:0] r;
    case (ctrl)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SLT:  r = (a < b) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_MFHI: r = h;
      OP_MFLO: r = l;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // One iteration of shift-add multiply and restoring divide on the work registers.
  always_comb begin
    mul_sum_s   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_s    = mul_sum_s[WIDTH:1];
    mul_lo_s    = {mul_sum_s[0], work_lo_q[WIDTH-1:1]};
    div_shift_s = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    if (div_diff_s[WIDTH]) begin
      div_rem_s = div_shift_s[WIDTH-1:0];
      div_quo_s = {work_lo_q[WIDTH-2:0], 1'b0};
    end else begin
      div_rem_s = div_diff_s[WIDTH-1:0];
      div_quo_s = {work_lo_q[WIDTH-2:0], 1'b1};
    end
    last_s = (cnt_q == CNT_W'(WIDTH-1));
  end

  // Next-state logic; results commit only on the final iteration so hi/lo never show partials.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    result_d  = result_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ALUCtrl == OP_MULT) begin
            state_d   = MUL;
            busy_d    = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            work_hi_d = {WIDTH{1'b0}};
            work_lo_d = read_data_2;
            opnd_d    = read_data_1;
          end else if ((ALUCtrl == OP_DIV) && (read_data_2 != {WIDTH{1'b0}})) begin
            state_d   = DIV;
            busy_d    = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            work_hi_d = {WIDTH{1'b0}};
            work_lo_d = read_data_1;
            opnd_d    = read_data_2;
          end else if (ALUCtrl == OP_DIV) begin
            lo_d     = {WIDTH{1'b1}};
            hi_d     = read_data_1;
            result_d = {WIDTH{1'b1}};
            dbz_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            result_d = single_op(ALUCtrl, read_data_1, read_data_2, shamt, hi_q, lo_q);
            dbz_d    = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (last_s) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          dbz_d    = 1'b0;
          hi_d     = mul_hi_s;
          lo_d     = mul_lo_s;
          result_d = mul_lo_s;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          work_hi_d = mul_hi_s;
          work_lo_d = mul_lo_s;
        end
      end
      DIV: begin
        if (last_s) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          dbz_d    = 1'b0;
          hi_d     = div_rem_s;
          lo_d     = div_quo_s;
          result_d = div_quo_s;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          work_hi_d = div_rem_s;
          work_lo_d = div_quo_s;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over any pending start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      work_hi_q <= {WIDTH{1'b0}};
      work_lo_q <= {WIDTH{1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign ALU_result  = result_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign Zero        = (result_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: issued ops push expected results from an
// arithmetic reference model; a negedge monitor pops and compares on every done.
module tb_multicycle_alu;
  localparam int W = 32;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_DIV = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111, C_SRL = 4'b1000;
  localparam logic [3:0] C_NOT = 4'b1001, C_SRA = 4'b1010, C_XOR = 4'b1011, C_MFHI = 4'b1100;
  localparam logic [3:0] C_MFLO = 4'b1101, C_MULT = 4'b1111;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [3:0]   ALUCtrl;
  logic [W-1:0] read_data_1, read_data_2;
  logic [4:0]   shamt;
  logic         busy, done, Zero, div_by_zero;
  logic [W-1:0] ALU_result, hi, lo;

  always #5 clock = ~clock;

  multicycle_alu dut (
    .clock(clock), .reset(reset), .start(start), .ALUCtrl(ALUCtrl),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .shamt(shamt),
    .busy(busy), .done(done), .ALU_result(ALU_result), .hi(hi), .lo(lo),
    .Zero(Zero), .div_by_zero(div_by_zero)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_checks = 0, n_fail = 0, n_issued = 0, n_done = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_last = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural effect of each opcode.
  task automatic issue_model(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [4:0] sh);
    exp_t           e;
    logic [2*W-1:0] p;
    logic [W-1:0]   ones;
    ones  = {W{1'b1}};
    e.dbz = 1'b0;
    case (ctrl)
      C_ADD:  e.res = a + b;
      C_SUB:  e.res = a - b;
      C_AND:  e.res = a & b;
      C_OR:   e.res = a | b;
      C_XOR:  e.res = a ^ b;
      C_NOT:  e.res = ~a;
      C_SLT:  e.res = (a < b) ? 32'd1 : 32'd0;
      C_SLL:  e.res = a << sh;
      C_SRL:  e.res = a >> sh;
      C_SRA:  e.res = (a >> sh) | (a[W-1] ? ~(ones >> sh) : 32'd0);
      C_MFHI: e.res = m_hi;
      C_MFLO: e.res = m_lo;
      C_MULT: begin
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_hi  = p[2*W-1:W];
        m_lo  = p[W-1:0];
        e.res = m_lo;
      end
      C_DIV: begin
        if (b == 32'd0) begin
          m_lo  = ones;
          m_hi  = a;
          e.dbz = 1'b1;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        e.res = m_lo;
      end
      default: e.res = 32'd0;
    endcase
    e.hi   = m_hi;
    e.lo   = m_lo;
    m_last = e.res;
    exp_q.push_back(e);
    n_issued++;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("done_with_empty_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 64'(ALU_result), 64'(mon_e.res));
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        chk("zero_flag", 64'(Zero), 64'(mon_e.res == 32'd0));
      end
    end
  end

  // Issue one op at the current negedge, scramble inputs while waiting, return on the done negedge.
  task automatic run_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input int repulse_at);
    int lat, busy_cycles, exp_lat, exp_busy;
    bit iter;
    iter        = (ctrl == C_MULT) || ((ctrl == C_DIV) && (b != 32'd0));
    exp_lat     = iter ? W + 1 : 1;
    exp_busy    = iter ? W : 0;
    ALUCtrl     = ctrl;
    read_data_1 = a;
    read_data_2 = b;
    shamt       = sh;
    start       = 1'b1;
    issue_model(ctrl, a, b, sh);
    lat         = 0;
    busy_cycles = 0;
    while (1) begin
      @(negedge clock);
      lat++;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1 || lat >= 3 * W) break;
      start       = (lat == repulse_at);
      ALUCtrl     = start ? C_ADD : 4'($urandom);
      read_data_1 = $urandom;
      read_data_2 = $urandom;
      shamt       = 5'($urandom);
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(ALU_result), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'd0);
    chk({tag, "_lo"}, 64'(lo), 64'd0);
    chk({tag, "_zero"}, 64'(Zero), 64'd1);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] codes[14];
    logic [3:0] c;
    logic [W-1:0] a, b;
    int nd;
    codes = '{C_AND, C_OR, C_ADD, C_DIV, C_SLL, C_SUB, C_SLT, C_SRL,
              C_NOT, C_SRA, C_XOR, C_MFHI, C_MFLO, C_MULT};
    reset = 1'b1; start = 1'b0; ALUCtrl = 4'd0;
    read_data_1 = '0; read_data_2 = '0; shamt = '0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clock);

    run_op(C_ADD, 32'd7, 32'd5, 5'd0, -1);
    run_op(C_SUB, 32'd5, 32'd5, 5'd0, -1);
    run_op(C_SRA, 32'h8000_0000, 32'd0, 5'd4, -1);
    run_op(C_MULT, 32'hFFFF_FFFF, 32'd2, 5'd0, -1);
    run_op(C_MFHI, 32'd0, 32'd0, 5'd0, -1);
    run_op(C_MFLO, 32'd0, 32'd0, 5'd0, -1);
    run_op(C_DIV, 32'd100, 32'd7, 5'd0, 5);
    run_op(C_DIV, 32'd9, 32'd0, 5'd0, -1);
    run_op(C_ADD, 32'd1, 32'd2, 5'd0, -1);
    run_op(4'b0100, 32'd3, 32'd4, 5'd0, -1);

    repeat (3) @(negedge clock);
    chk("hold_result", 64'(ALU_result), 64'(m_last));
    chk("hold_hi", 64'(hi), 64'(m_hi));
    chk("hold_lo", 64'(lo), 64'(m_lo));

    // Abort a multiply ten cycles in; no done may follow.
    ALUCtrl = C_MULT; read_data_1 = $urandom; read_data_2 = $urandom; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check_cleared("abort");
    m_hi = '0; m_lo = '0;
    nd = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run_op(C_ADD, 32'd20, 32'd22, 5'd0, -1);

    for (int i = 0; i < 80; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 13)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      run_op(c, a, b, 5'($urandom), (i % 5 == 0) ? 3 : -1);
    end

    repeat (2) @(negedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
